alu_issue_ctrl: RTL and testbench

Issue controller that sits directly upstream of the 8-bit combinational ALU. It accepts instructions over a valid/ready handshake and reads operands from an internal 8×8 register file. It drives registered `ctrl`/`x`/`y` into the ALU, captures `out`/`carry`, then presents the result downstream and writes it back to the register file.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/reg_file.sv | 29 ++
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcodes, FSM encoding and instruction payload for the ALU issue controller.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREG   = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOT = 4'b0100;
  localparam logic [OP_W-1:0] OP_LDI = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Opcodes that actually drive the external ALU.
  function automatic logic op_uses_alu(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_file.sv
// NREG x DATA_W register file: two combinational read ports, one synchronous write port.
module reg_file
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 8-bit combinational ALU: fetch operands, drive ALU,
// capture result, hand it downstream and write it back.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic              in_imm_sel,
  input  logic [DATA_W-1:0] in_imm,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic [ADDR_W-1:0] res_rd,
  output logic              res_err
);

  state_t            state, state_nxt;
  instr_t            ins;
  logic [DATA_W-1:0] rf_x, rf_y, op_y;
  logic              rf_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_READ;
      ST_READ:                state_nxt = ST_EXEC;
      ST_EXEC:                state_nxt = ST_WB;
      ST_WB:   if (res_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins <= '0;
    end else if (in_ready && in_valid) begin
      ins <= '{op: in_op, rd: in_rd, rs: in_rs, rt: in_rt,
               imm_sel: in_imm_sel, imm: in_imm};
    end
  end

  reg_file u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ins.rs),
    .ra_data (rf_x),
    .rb_addr (ins.rt),
    .rb_data (rf_y),
    .we      (rf_we),
    .wa      (res_rd),
    .wd      (res_data)
  );

  assign op_y = ins.imm_sel ? ins.imm : rf_y;

  // LDI and illegal opcodes park the ALU on a harmless AND of zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
    end else if (state == ST_READ) begin
      if (op_uses_alu(ins.op)) begin
        alu_ctrl <= ins.op;
        alu_x    <= rf_x;
        alu_y    <= op_y;
      end else begin
        alu_ctrl <= OP_AND;
        alu_x    <= '0;
        alu_y    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_rd    <= '0;
      res_err   <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_valid <= 1'b1;
      res_rd    <= ins.rd;
      case (ins.op)
        OP_ADD, OP_SUB: begin
          res_data  <= alu_out;
          res_carry <= alu_carry;
          res_err   <= 1'b0;
        end
        OP_AND, OP_OR, OP_NOT: begin
          res_data  <= alu_out;
          res_carry <= 1'b0;
          res_err   <= 1'b0;
        end
        OP_LDI: begin
          res_data  <= ins.imm;
          res_carry <= 1'b0;
          res_err   <= 1'b0;
        end
        default: begin
          res_data  <= '0;
          res_carry <= 1'b0;
          res_err   <= 1'b1;
        end
      endcase
    end else if (state == ST_WB && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Write-back happens only on the downstream handshake, so a stall never writes twice.
  assign rf_we = (state == ST_WB) && res_ready && !res_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a register-file model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs, in_rt;
  logic       in_imm_sel;
  logic [7:0] in_imm;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic [2:0] res_rd;
  logic       res_err;

  int checks = 0;
  int errors = 0;
  int rf [8];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_rd(res_rd), .res_err(res_err)
  );

  // External combinational ALU
  logic [8:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      4'b0000: alu_res = {1'b0, alu_x} + {1'b0, alu_y};
      4'b0001: alu_res = {1'b0, alu_x} - {1'b0, alu_y};
      4'b0010: alu_res = {1'b0, alu_x & alu_y};
      4'b0011: alu_res = {1'b0, alu_x | alu_y};
      4'b0100: alu_res = {1'b0, ~alu_x};
      default: alu_res = '0;
    endcase
  end
  assign alu_out   = alu_res[7:0];
  assign alu_carry = alu_res[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, hold back-pressure for 'stall' cycles, then complete it.
  task automatic issue(input logic [3:0] op, input int rd, input int rs, input int rt,
                       input logic isel, input int imm, input int stall);
    int a, b, e_data, e_carry, e_err, e_ctrl, e_x, e_y, n;
    a = rf[rs];
    b = isel ? imm : rf[rt];
    e_carry = 0; e_err = 0; e_ctrl = 2; e_x = 0; e_y = 0;
    case (op)
      4'h0: begin e_data = (a + b) % 256; e_carry = (a + b > 255) ? 1 : 0; end
      4'h1: begin e_data = (a - b + 256) % 256; e_carry = (a < b) ? 1 : 0; end
      4'h2: e_data = a & b;
      4'h3: e_data = a | b;
      4'h4: e_data = 255 - a;
      4'hF: e_data = imm;
      default: begin e_data = 0; e_err = 1; end
    endcase
    if (op <= 4'h4) begin e_ctrl = int'(op); e_x = a; e_y = b; end

    @(negedge clk);
    in_op = op; in_rd = 3'(rd); in_rs = 3'(rs); in_rt = 3'(rt);
    in_imm_sel = isel; in_imm = 8'(imm); in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 10) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd3);
    check("res_data", 32'(res_data), 32'(e_data));
    check("res_carry", 32'(res_carry), 32'(e_carry));
    check("res_err", 32'(res_err), 32'(e_err));
    check("res_rd", 32'(res_rd), 32'(rd));
    check("alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
    check("alu_x", 32'(alu_x), 32'(e_x));
    check("alu_y", 32'(alu_y), 32'(e_y));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_data", 32'(res_data), 32'(e_data));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", 32'(res_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    if (e_err == 0) rf[rd] = e_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_alu"}, {20'd0, alu_ctrl, alu_x}, 32'd0);
    check({tag, "_alu_y"}, 32'(alu_y), 32'd0);
    check({tag, "_res"}, {20'd0, res_carry, res_err, res_rd, res_data}, 32'd0);
  endtask

  initial begin
    int op_sel;
    logic [3:0] rop;
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm_sel = 1'b0; in_imm = '0;
    for (int i = 0; i < 8; i++) rf[i] = 0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) issue(4'h3, i, i, i, 1'b0, 0, 0);

    issue(4'hF, 1, 0, 0, 1'b1, 8'h05, 0);
    issue(4'hF, 2, 0, 0, 1'b1, 8'h03, 0);
    issue(4'h1, 3, 1, 2, 1'b0, 0, 0);
    check("sub_pos", 32'(rf[3]), 32'h02);
    issue(4'h1, 4, 2, 1, 1'b0, 0, 0);
    check("sub_neg", 32'(rf[4]), 32'hFE);
    issue(4'h0, 5, 1, 0, 1'b1, 8'hFF, 0);
    check("add_imm", 32'(rf[5]), 32'h04);
    issue(4'h4, 6, 1, 0, 1'b0, 0, 0);
    check("not", 32'(rf[6]), 32'hFA);

    issue(4'h0, 7, 3, 4, 1'b0, 0, 5);
    issue(4'h3, 0, 7, 7, 1'b0, 0, 0);

    issue(4'h7, 2, 1, 1, 1'b0, 0, 1);
    issue(4'h3, 2, 2, 2, 1'b0, 0, 0);
    check("illegal_keep", 32'(rf[2]), 32'h03);

    for (int k = 0; k < 40; k++) begin
      op_sel = int'($urandom_range(0, 7));
      case (op_sel)
        0: rop = 4'h0;
        1: rop = 4'h1;
        2: rop = 4'h2;
        3: rop = 4'h3;
        4: rop = 4'h4;
        5: rop = 4'hF;
        6: rop = 4'h0;
        default: rop = 4'($urandom_range(5, 14));
      endcase
      issue(rop, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    issue(4'hF, 1, 0, 0, 1'b1, 8'h21, 0);
    @(negedge clk);
    in_op = 4'h0; in_rd = 3'd1; in_rs = 3'd1; in_rt = 3'd1; in_imm_sel = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_pulse", 32'(res_valid), 32'd0);
    end
    for (int i = 0; i < 8; i++) rf[i] = 0;
    issue(4'h3, 1, 1, 1, 1'b0, 0, 0);
    check("r1_cleared", 32'(rf[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
